// File: rtl/haar_cascade_sequencer.sv
// Haar cascade sequencer: walks the stage table for one detection window.
// Each stage descriptor is fetched from stage RAM, the weak-classifier
// evaluator is launched, and its verdict either advances to the next stage
// or terminates the window early. One decision is issued per accepted start.
module haar_cascade_sequencer #(
    parameter int NUM_STAGES = 25,
    parameter int ADDR_W     = 16,
    parameter int ROM_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              win_start,
    input  logic              abort,
    output logic              busy,
    output logic [ADDR_W-1:0] stage_addr,
    input  logic [31:0]       stage_data,
    output logic              ev_start,
    output logic [ADDR_W-1:0] ev_start_addr,
    output logic [15:0]       ev_num_weak,
    input  logic              ev_done,
    input  logic              ev_pass,
    output logic              decision_valid,
    output logic              haar_decision,
    output logic [7:0]        stages_passed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT,
        S_REPORT
    } state_t;

    localparam logic [1:0] LAT_LAST   = 2'(ROM_LAT - 1);
    localparam logic [7:0] LAST_STAGE = 8'(NUM_STAGES - 1);

    state_t              state_reg, state_next;
    logic [7:0]          idx_reg;
    logic [1:0]          lat_cnt_reg;
    logic [ADDR_W-1:0]   ev_addr_reg;
    logic [15:0]         ev_num_reg;
    logic                haar_reg;
    logic [7:0]          passed_reg;

    // Action strobes decoded by the FSM and consumed by the datapath
    logic                do_latch;
    logic                stage_pass;
    logic                stage_fail;
    logic                is_last;
    logic                aborting;

    assign is_last  = (idx_reg == LAST_STAGE);
    assign aborting = abort && (state_reg != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-cycle control decode; abort overrides everything else
    always_comb begin
        state_next = state_reg;
        ev_start   = 1'b0;
        do_latch   = 1'b0;
        stage_pass = 1'b0;
        stage_fail = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (win_start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    do_latch   = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // A stage with no weak classifiers passes without the evaluator
                if (ev_num_reg != 16'd0) begin
                    ev_start   = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    stage_pass = 1'b1;
                end
            end
            S_WAIT: begin
                if (ev_done) begin
                    if (ev_pass) begin
                        stage_pass = 1'b1;
                    end else begin
                        stage_fail = 1'b1;
                    end
                end
            end
            S_REPORT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (stage_pass) begin
            state_next = is_last ? S_REPORT : S_FETCH;
        end
        if (stage_fail) begin
            state_next = S_REPORT;
        end

        // An abandoned window must not launch the evaluator or score a stage
        if (aborting) begin
            state_next = S_IDLE;
            ev_start   = 1'b0;
            do_latch   = 1'b0;
            stage_pass = 1'b0;
            stage_fail = 1'b0;
        end
    end

    // Datapath: stage index, RAM latency counter, descriptor latch, verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg     <= 8'd0;
            lat_cnt_reg <= 2'd0;
            ev_addr_reg <= '0;
            ev_num_reg  <= 16'd0;
            haar_reg    <= 1'b0;
            passed_reg  <= 8'd0;
        end else begin
            if ((state_reg == S_IDLE) && win_start) begin
                idx_reg    <= 8'd0;
                passed_reg <= 8'd0;
                haar_reg   <= 1'b0;
            end

            // Counter restarts on every FETCH entry so each stage waits ROM_LAT cycles
            if ((state_reg == S_FETCH) && (state_next == S_FETCH)) begin
                lat_cnt_reg <= lat_cnt_reg + 2'd1;
            end else begin
                lat_cnt_reg <= 2'd0;
            end

            if (do_latch) begin
                ev_num_reg  <= stage_data[31:16];
                ev_addr_reg <= ADDR_W'(stage_data[15:0]);
            end

            if (stage_pass) begin
                if (passed_reg != 8'hFF) begin
                    passed_reg <= passed_reg + 8'd1;
                end
                if (is_last) begin
                    haar_reg <= 1'b1;
                end else begin
                    idx_reg <= idx_reg + 8'd1;
                end
            end

            if (stage_fail || aborting) begin
                haar_reg <= 1'b0;
            end
        end
    end

    assign busy           = (state_reg != S_IDLE);
    assign decision_valid = (state_reg == S_REPORT);
    assign stage_addr     = ADDR_W'(idx_reg);
    assign ev_start_addr  = ev_addr_reg;
    assign ev_num_weak    = ev_num_reg;
    assign haar_decision  = haar_reg;
    assign stages_passed  = passed_reg;

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Directed bench for haar_cascade_sequencer: one instance with ROM_LAT=1 for
// the functional cases and one with ROM_LAT=3 for latency and reset-in-WAIT.
`timescale 1ns/1ps
module tb_haar_cascade_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ROM_LAT = 1 instance
    logic        reset, win_start, abort, ev_done, ev_pass;
    logic        busy, ev_start, decision_valid, haar_decision;
    logic [15:0] stage_addr, ev_start_addr, ev_num_weak;
    logic [31:0] stage_data;
    logic [7:0]  stages_passed;

    // ROM_LAT = 3 instance
    logic        reset3, win_start3, abort3, ev_done3, ev_pass3;
    logic        busy3, ev_start3, decision_valid3, haar_decision3;
    logic [15:0] stage_addr3, ev_start_addr3, ev_num_weak3;
    logic [31:0] stage_data3;
    logic [7:0]  stages_passed3;

    logic [31:0] stage_tbl [0:2];

    int n_checks = 0;
    int n_errors = 0;

    haar_cascade_sequencer #(.NUM_STAGES(3), .ADDR_W(16), .ROM_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .win_start(win_start), .abort(abort),
        .busy(busy), .stage_addr(stage_addr), .stage_data(stage_data),
        .ev_start(ev_start), .ev_start_addr(ev_start_addr), .ev_num_weak(ev_num_weak),
        .ev_done(ev_done), .ev_pass(ev_pass), .decision_valid(decision_valid),
        .haar_decision(haar_decision), .stages_passed(stages_passed)
    );

    haar_cascade_sequencer #(.NUM_STAGES(3), .ADDR_W(16), .ROM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset3), .win_start(win_start3), .abort(abort3),
        .busy(busy3), .stage_addr(stage_addr3), .stage_data(stage_data3),
        .ev_start(ev_start3), .ev_start_addr(ev_start_addr3), .ev_num_weak(ev_num_weak3),
        .ev_done(ev_done3), .ev_pass(ev_pass3), .decision_valid(decision_valid3),
        .haar_decision(haar_decision3), .stages_passed(stages_passed3)
    );

    // Stage RAM model: descriptor held steady while the address is steady
    always_comb begin
        stage_data  = 32'h0;
        stage_data3 = 32'h0;
        if (stage_addr < 16'd3)  stage_data  = stage_tbl[stage_addr[1:0]];
        if (stage_addr3 < 16'd3) stage_data3 = stage_tbl[stage_addr3[1:0]];
    end

    // Monitor logs for the ROM_LAT=1 instance (callers diff against a baseline)
    int          ev_cnt = 0;
    int          dv_cnt = 0;
    int          addr2_cnt = 0;
    int          ev_addr_log [0:15];
    int          ev_num_log  [0:15];
    int          dv_haar = 0;
    int          dv_passed = 0;

    always @(negedge clk) begin
        if (ev_start) begin
            ev_addr_log[ev_cnt % 16] = int'(ev_start_addr);
            ev_num_log[ev_cnt % 16]  = int'(ev_num_weak);
            $display("  ev_start #%0d addr=%0d num=%0d", ev_cnt, ev_start_addr, ev_num_weak);
            ev_cnt = ev_cnt + 1;
        end
        if (decision_valid) begin
            dv_cnt    = dv_cnt + 1;
            dv_haar   = int'(haar_decision);
            dv_passed = int'(stages_passed);
            $display("  decision haar=%0d passed=%0d", haar_decision, stages_passed);
        end
        if (busy && stage_addr == 16'd2) addr2_cnt = addr2_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One window on the ROM_LAT=1 instance. The evaluator answers two cycles
    // after each ev_start; the ev_start with ordinal fail_ord gets ev_pass=0.
    // With spur set, a stray ev_done is driven during FETCH and win_start is
    // pulsed during the first WAIT.
    task automatic run_window(input int fail_ord, input bit spur,
                              output int first_lat, output int first_addr, output bit got_dv);
        int t;
        int nord;
        first_lat = -1;
        got_dv    = 1'b0;
        nord      = 0;
        @(negedge clk); win_start = 1'b1;
        @(negedge clk); win_start = 1'b0; t = 1;
        first_addr = int'(stage_addr);
        if (spur) begin
            ev_done = 1'b1; ev_pass = 1'b0;
            @(negedge clk); t++;
            ev_done = 1'b0;
        end
        while (!got_dv && t < 300) begin
            if (decision_valid) begin
                got_dv = 1'b1;
            end else if (ev_start) begin
                if (first_lat < 0) first_lat = t;
                @(negedge clk); t++;
                win_start = spur && (nord == 0);
                @(negedge clk); t++;
                win_start = 1'b0;
                ev_done = 1'b1;
                ev_pass = (nord != fail_ord);
                nord++;
                @(negedge clk); t++;
                ev_done = 1'b0; ev_pass = 1'b0;
            end else begin
                @(negedge clk); t++;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    int  b_ev, b_dv, b_a2, lat, faddr, t;
    bit  got;

    initial begin
        reset = 1'b1; win_start = 1'b0; abort = 1'b0; ev_done = 1'b0; ev_pass = 1'b0;
        reset3 = 1'b1; win_start3 = 1'b0; abort3 = 1'b0; ev_done3 = 1'b0; ev_pass3 = 1'b0;
        stage_tbl[0] = {16'd2, 16'h0000};
        stage_tbl[1] = {16'd3, 16'h0002};
        stage_tbl[2] = {16'd1, 16'h0005};
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", int'(busy), 0);
        check("rst_ev_start", int'(ev_start), 0);
        check("rst_dv", int'(decision_valid), 0);
        check("rst_haar", int'(haar_decision), 0);
        check("rst_passed", int'(stages_passed), 0);
        check("rst_stage_addr", int'(stage_addr), 0);
        check("rst_ev_addr", int'(ev_start_addr), 0);
        check("rst_ev_num", int'(ev_num_weak), 0);
        reset = 1'b0; reset3 = 1'b0;
        @(negedge clk);

        // 1: all stages pass
        b_ev = ev_cnt; b_dv = dv_cnt;
        run_window(99, 1'b0, lat, faddr, got);
        $display("T1 all-pass: ev=%0d dv=%0d haar=%0d passed=%0d", ev_cnt - b_ev, dv_cnt - b_dv, dv_haar, dv_passed);
        check("t1_got_dv", int'(got), 1);
        check("t1_first_addr", faddr, 0);
        check("t1_ev_latency", lat, 2);
        check("t1_ev_count", ev_cnt - b_ev, 3);
        check("t1_ev0_addr", ev_addr_log[(b_ev + 0) % 16], 0);
        check("t1_ev0_num", ev_num_log[(b_ev + 0) % 16], 2);
        check("t1_ev1_addr", ev_addr_log[(b_ev + 1) % 16], 2);
        check("t1_ev1_num", ev_num_log[(b_ev + 1) % 16], 3);
        check("t1_ev2_addr", ev_addr_log[(b_ev + 2) % 16], 5);
        check("t1_ev2_num", ev_num_log[(b_ev + 2) % 16], 1);
        check("t1_dv_count", dv_cnt - b_dv, 1);
        check("t1_haar", dv_haar, 1);
        check("t1_passed", dv_passed, 3);
        check("t1_busy_after", int'(busy), 0);
        check("t1_haar_held", int'(haar_decision), 1);

        // 2: stage 1 fails, early exit
        b_ev = ev_cnt; b_dv = dv_cnt; b_a2 = addr2_cnt;
        run_window(1, 1'b0, lat, faddr, got);
        $display("T2 early-exit: ev=%0d dv=%0d haar=%0d passed=%0d", ev_cnt - b_ev, dv_cnt - b_dv, dv_haar, dv_passed);
        check("t2_ev_count", ev_cnt - b_ev, 2);
        check("t2_addr2_seen", addr2_cnt - b_a2, 0);
        check("t2_dv_count", dv_cnt - b_dv, 1);
        check("t2_haar", dv_haar, 0);
        check("t2_passed", dv_passed, 1);

        // 3: empty stage 1 passes automatically
        stage_tbl[1] = {16'd0, 16'h0009};
        b_ev = ev_cnt; b_dv = dv_cnt;
        run_window(99, 1'b0, lat, faddr, got);
        $display("T3 auto-pass: ev=%0d dv=%0d haar=%0d passed=%0d", ev_cnt - b_ev, dv_cnt - b_dv, dv_haar, dv_passed);
        check("t3_ev_count", ev_cnt - b_ev, 2);
        check("t3_ev1_addr", ev_addr_log[(b_ev + 1) % 16], 5);
        check("t3_dv_count", dv_cnt - b_dv, 1);
        check("t3_haar", dv_haar, 1);
        check("t3_passed", dv_passed, 3);
        stage_tbl[1] = {16'd3, 16'h0002};

        // 4: stray ev_done in FETCH and win_start in WAIT are both ignored
        b_ev = ev_cnt; b_dv = dv_cnt;
        run_window(99, 1'b1, lat, faddr, got);
        repeat (5) @(negedge clk);
        $display("T4 spurious: ev=%0d dv=%0d haar=%0d passed=%0d busy=%0d", ev_cnt - b_ev, dv_cnt - b_dv, dv_haar, dv_passed, busy);
        check("t4_ev_count", ev_cnt - b_ev, 3);
        check("t4_dv_count", dv_cnt - b_dv, 1);
        check("t4_haar", dv_haar, 1);
        check("t4_passed", dv_passed, 3);
        check("t4_no_restart", int'(busy), 0);

        // 5: abort coincident with ev_done of stage 0
        b_dv = dv_cnt;
        @(negedge clk); win_start = 1'b1;
        @(negedge clk); win_start = 1'b0;
        t = 0;
        while (!ev_start && t < 20) begin
            @(negedge clk); t++;
        end
        check("t5_ev_start_seen", int'(ev_start), 1);
        @(negedge clk);
        ev_done = 1'b1; ev_pass = 1'b1; abort = 1'b1;
        @(negedge clk);
        ev_done = 1'b0; ev_pass = 1'b0; abort = 1'b0;
        $display("T5 abort: busy=%0d haar=%0d passed=%0d", busy, haar_decision, stages_passed);
        check("t5_busy", int'(busy), 0);
        check("t5_haar", int'(haar_decision), 0);
        check("t5_passed", int'(stages_passed), 0);
        repeat (3) @(negedge clk);
        check("t5_no_dv", dv_cnt - b_dv, 0);
        b_ev = ev_cnt;
        run_window(99, 1'b0, lat, faddr, got);
        $display("T5 restart: first_addr=%0d ev=%0d passed=%0d", faddr, ev_cnt - b_ev, dv_passed);
        check("t5_restart_addr", faddr, 0);
        check("t5_restart_ev0_addr", ev_addr_log[b_ev % 16], 0);
        check("t5_restart_passed", dv_passed, 3);

        // 6: ROM_LAT=3, reset during WAIT, then latency of a fresh run
        @(negedge clk); win_start3 = 1'b1;
        @(negedge clk); win_start3 = 1'b0;
        t = 0;
        while (!ev_start3 && t < 20) begin
            @(negedge clk); t++;
        end
        check("t6_ev_start_seen", int'(ev_start3), 1);
        @(negedge clk);
        check("t6_in_wait_busy", int'(busy3), 1);
        reset3 = 1'b1;
        @(negedge clk);
        reset3 = 1'b0;
        $display("T6 reset-in-wait: busy=%0d ev_addr=%0d ev_num=%0d", busy3, ev_start_addr3, ev_num_weak3);
        check("t6_busy", int'(busy3), 0);
        check("t6_ev_start", int'(ev_start3), 0);
        check("t6_dv", int'(decision_valid3), 0);
        check("t6_ev_num", int'(ev_num_weak3), 0);
        check("t6_ev_addr", int'(ev_start_addr3), 0);
        check("t6_stage_addr", int'(stage_addr3), 0);
        check("t6_passed", int'(stages_passed3), 0);
        @(negedge clk); win_start3 = 1'b1;
        @(negedge clk); win_start3 = 1'b0; t = 1;
        while (!ev_start3 && t < 20) begin
            @(negedge clk); t++;
        end
        $display("T6 rom_lat3 latency=%0d num=%0d", t, ev_num_weak3);
        check("t6_latency", t, 4);
        check("t6_ev_num_run", int'(ev_num_weak3), 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/haar_cascade_sequencer.md
Name: haar_cascade_sequencer

Overview:
- Controller that walks the Haar cascade stage table for one detection window.
- Per stage: fetches the stage descriptor from stage block RAM, launches the per-stage weak-classifier evaluator, waits for its verdict, then either advances or exits early on the first failing stage.
- Issues one window decision per start request.
- Sits between the window scanner (requester) and the stage evaluator/stage RAM pair.

Parameters:
- NUM_STAGES, 25, number of cascade stages in the table (1..255).
- ADDR_W, 16, stage RAM address width and weak-classifier address width.
- ROM_LAT, 1, stage RAM read latency in cycles (1..3).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- win_start  in  1  one-cycle request to evaluate a new window; honoured only in IDLE
- abort  in  1  cancel current window; return to IDLE with no decision
- busy  out  1  high from the cycle after an accepted win_start until back in IDLE
- stage_addr  out  ADDR_W  stage RAM read address (= current stage index)
- stage_data  in  32  stage descriptor: [31:16] weak-classifier count, [15:0] first weak-classifier address
- ev_start  out  1  one-cycle launch pulse to the stage evaluator
- ev_start_addr  out  ADDR_W  registered first weak-classifier address; stable from ev_start until ev_done
- ev_num_weak  out  16  registered weak-classifier count; stable from ev_start until ev_done
- ev_done  in  1  evaluator finished current stage (single-cycle pulse)
- ev_pass  in  1  stage verdict, sampled only when ev_done=1
- decision_valid  out  1  one-cycle pulse, window verdict available
- haar_decision  out  1  1 = face (all stages passed); held until next accepted win_start
- stages_passed  out  8  count of stages passed in current/last window; held like haar_decision

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE; stage index=0; busy=0; ev_start=0; decision_valid=0; haar_decision=0; stages_passed=0.
  - stage_addr=0; ev_start_addr=0; ev_num_weak=0.
- FSM states: IDLE, FETCH, LAUNCH, WAIT, REPORT.
- IDLE:
  - On win_start=1, move to FETCH next cycle.
  - Clear the stage index, stages_passed and haar_decision.
- FETCH:
  - Drive stage_addr = stage index.
  - Wait exactly ROM_LAT cycles, then latch stage_data into ev_num_weak/ev_start_addr and go to LAUNCH.
- LAUNCH:
  - If ev_num_weak≠0: ev_start=1 for this single cycle, then go to WAIT.
  - If ev_num_weak==0: the stage is an automatic pass. No ev_start; apply the pass rule from WAIT directly.
- WAIT:
  - Hold until ev_done=1.
  - ev_pass=1: increment stages_passed. If stage index==NUM_STAGES-1, set haar_decision=1 and go to REPORT. Otherwise increment the stage index and go to FETCH.
  - ev_pass=0: set haar_decision=0 and go to REPORT (early exit; remaining stages are not fetched).
- REPORT: decision_valid=1 for one cycle, then IDLE.
- Timing for a single passing stage with ROM_LAT=1:
  - win_start at cycle T.
  - stage_addr valid at T+1.
  - ev_start at T+2.
  - If ev_done arrives at T+2+k, REPORT is at T+3+k.
- ev_done received in any state other than WAIT is ignored.
- win_start while busy is ignored (not queued).
- abort:
  - Takes effect in any non-IDLE state: next state IDLE, no decision_valid pulse.
  - haar_decision forced to 0; stages_passed keeps its partial count.
  - abort has priority over ev_done in the same cycle.
- Reset mid-window overrides everything and produces no decision_valid.
- stages_passed saturates at 255 and never wraps.
- stage_addr zero-extends the 8-bit stage index to ADDR_W.

Test Plan:
- NUM_STAGES=3; table {(2,0x0000),(3,0x0002),(1,0x0005)}; evaluator passes all → ev_start three times with (addr,num) = (0,2), (2,3), (5,1); decision_valid once; haar_decision=1; stages_passed=3.
- Same table; stage 1 returns ev_pass=0 → only two ev_start pulses; stage_addr never reaches 2; decision_valid with haar_decision=0, stages_passed=1.
- Table entry 1 = (0,0x0009), others pass → no ev_start for stage 1; final haar_decision=1, stages_passed=3.
- win_start pulsed during WAIT, plus a spurious ev_done during FETCH → both ignored; exactly one decision_valid per accepted start.
- abort asserted in the same cycle as ev_done of stage 0 → return to IDLE, no decision_valid, haar_decision=0; a new win_start then restarts at stage_addr=0.
- ROM_LAT=3 with reset asserted during WAIT → outputs at reset values next cycle; a subsequent run shows ev_start exactly 4 cycles after win_start.
